// File: rtl/apb_master_pkg.sv
// Shared types for the APB master bridge: FSM states, response payload and timeout counter width.
package apb_master_pkg;

    localparam int TIMEOUT_CNT_W = 16;
    localparam int RSP_DATA_W    = 32;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_t;

    typedef struct packed {
        logic [RSP_DATA_W-1:0] rdata;
        logic                  err;
    } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// Wait-state counter for the APB ACCESS phase; o_expired flags that the count has reached the limit.
module apb_timeout_counter
    import apb_master_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clear,
    input  logic                     i_enable,
    input  logic [TIMEOUT_CNT_W-1:0] i_limit,
    output logic                     o_expired
);

    logic [TIMEOUT_CNT_W-1:0] r_cnt;

    // Holds at the limit so a late pready can never see a wrapped count.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expired) begin
            r_cnt <= r_cnt + TIMEOUT_CNT_W'(1);
        end
    end

    assign o_expired = (r_cnt == i_limit);

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to APB SETUP/ACCESS transfers, one outstanding transfer at a time.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              busy
);

    if (DATA_W != RSP_DATA_W || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_chk
        $error("apb_master_bridge: unsupported DATA_W or TIMEOUT_CYCLES");
    end

    apb_state_t        r_state;
    apb_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;
    apb_rsp_t          r_rsp;
    logic              w_accept;
    logic              w_expired;

    assign w_accept = (r_state == IDLE) && cmd_valid;

`ifdef APB_TIMEOUT_EN
    apb_timeout_counter u_timeout (
        .i_clk     (pclk),
        .i_rst     (rst),
        .i_clear   (r_state == SETUP),
        .i_enable  ((r_state == ACCESS) && !pready),
        .i_limit   (TIMEOUT_CNT_W'(TIMEOUT_CYCLES)),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (cmd_valid)            w_state_nxt = SETUP;
            SETUP:                             w_state_nxt = ACCESS;
            ACCESS:  if (pready || w_expired)  w_state_nxt = RESP;
            RESP:    if (rsp_ready)            w_state_nxt = IDLE;
            default:                           w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_rsp    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_paddr  <= cmd_addr;
                r_pwrite <= cmd_write;
                r_pwdata <= cmd_wdata;
            end
            // pready beats the timeout when both land in the same cycle.
            if (r_state == ACCESS) begin
                if (pready) begin
                    r_rsp.rdata <= r_pwrite ? '0 : prdata;
                    r_rsp.err   <= pslverr;
                end else if (w_expired) begin
                    r_rsp.rdata <= '0;
                    r_rsp.err   <= 1'b1;
                end
            end
        end
    end

    assign cmd_ready = (r_state == IDLE) && !rst;
    assign psel      = (r_state == SETUP) || (r_state == ACCESS);
    assign penable   = (r_state == ACCESS);
    assign busy      = (r_state != IDLE);
    assign rsp_valid = (r_state == RESP);
    assign paddr     = r_paddr;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;
    assign rsp_rdata = r_rsp.rdata;
    assign rsp_err   = r_rsp.err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: expected responses queued at command issue, checked at handshake.
module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          pclk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] paddr;
    logic          psel, penable, pwrite;
    logic [DW-1:0] pwdata, prdata;
    logic          pready, pslverr, busy;

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)) dut (
        .pclk(pclk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Response monitor: the handshake completes at the next posedge.
    always @(negedge pclk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            chk("rsp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", rsp_err, e.err);
            end
        end
    end

    // Issues one command from IDLE and walks it to RESP; slave errors and junk prdata are
    // driven on every non-completing cycle and must be ignored.
    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] rdata, input int waits, input logic err);
        exp_t e;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        pready = 1'b0; pslverr = 1'b1; prdata = ~rdata;
        chk("idle_cmd_ready", cmd_ready, 1);
        e.rdata = wr ? '0 : rdata;
        e.err   = err;
        exp_q.push_back(e);
        step();
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~wdata;
        chk("setup_ctl", {psel, penable, rsp_valid, cmd_ready, busy}, 5'b10001);
        chk("setup_paddr", paddr, addr);
        chk("setup_pwrite", pwrite, wr);
        if (wr) chk("setup_pwdata", pwdata, wdata);
        step();
        for (int i = 0; i < waits; i++) begin
            chk("wait_ctl", {psel, penable, rsp_valid, cmd_ready}, 4'b1100);
            chk("wait_paddr", paddr, addr);
            step();
        end
        pready = 1'b1; pslverr = err; prdata = rdata;
        chk("access_ctl", {psel, penable, rsp_valid, cmd_ready}, 4'b1100);
        chk("access_paddr", paddr, addr);
        if (wr) chk("access_pwdata", pwdata, wdata);
        step();
        pready = 1'b0; pslverr = 1'b1; prdata = $urandom;
        chk("resp_ctl", {psel, penable, rsp_valid, busy, cmd_ready}, 5'b00110);
        chk("resp_rdata_now", rsp_rdata, e.rdata);
        chk("resp_err_now", rsp_err, err);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        step(); step();
        chk("rst_ctl", {psel, penable, pwrite, rsp_valid, rsp_err, busy, cmd_ready}, 7'b0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rdata", rsp_rdata, 0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;

        // write, zero wait states
        xfer(1'b1, 32'h04, 32'h0000_0123, 32'h0, 0, 1'b0);
        step();
        chk("post_wr_busy", busy, 0);

        // read with three wait states
        xfer(1'b0, 32'h08, 32'h0, 32'h0000_00A5, 3, 1'b0);
        step();

        // slave errors, read and write
        xfer(1'b0, 32'h1C, 32'h0, 32'hDEAD_BEEF, 0, 1'b1);
        step();
        xfer(1'b1, 32'h1C, 32'h55, 32'h0, 2, 1'b1);
        step();

        // response backpressure with next command pending
        rsp_ready = 1'b0;
        xfer(1'b0, 32'h10, 32'h0, 32'h5A5A_5A5A, 1, 1'b0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'hBEEF;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ctl", {rsp_valid, cmd_ready, psel, busy}, 4'b1001);
            chk("bp_rdata", rsp_rdata, 32'h5A5A_5A5A);
            step();
        end
        rsp_ready = 1'b1;
        chk("bp_hs_cmd_ready", cmd_ready, 0);
        step();
        xfer(1'b1, 32'h20, 32'hBEEF, 32'h0, 0, 1'b0);
        step();

        // randomised mix
        for (int n = 0; n < 6; n++) begin
            logic          wr;
            logic [AW-1:0] a;
            wr = 1'($urandom_range(1));
            a  = $urandom & 32'hFFFC;
            xfer(wr, a, $urandom, $urandom, int'($urandom_range(3)), 1'($urandom_range(1)));
            step();
        end

        // reset during a wait state: no response may follow
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30; pready = 1'b0;
        step();
        cmd_valid = 1'b0;
        step(); step();
        chk("abort_pre", {psel, penable}, 2'b11);
        rst = 1'b1;
        step();
        chk("abort_ctl", {psel, penable, rsp_valid, busy}, 4'b0);
        rst = 1'b0; pready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_rsp", rsp_valid, 0);
            step();
        end
        pready = 1'b0;
        xfer(1'b0, 32'h34, 32'h0, 32'h1234_5678, 1, 1'b0);
        step();

`ifdef APB_TIMEOUT_EN
        // pready never arrives: abort when the wait count reaches the limit
        begin
            exp_t e;
            e.rdata = '0; e.err = 1'b1;
            exp_q.push_back(e);
        end
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; pready = 1'b0; prdata = 32'hFFFF;
        step();
        cmd_valid = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("to_wait_ctl", {psel, penable, rsp_valid}, 3'b110);
            step();
        end
        chk("to_resp_ctl", {psel, penable, rsp_valid}, 3'b001);
        chk("to_rdata", rsp_rdata, 0);
        chk("to_err", rsp_err, 1);
        step();
        // pready exactly at the limit completes normally
        xfer(1'b0, 32'h44, 32'h0, 32'h77, 4, 1'b0);
        step();
`endif

        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Initiator end of the APB bus used by the I2C register block. It turns a simple valid/ready command stream from a local controller (test sequencer, DMA or debug port) into compliant APB SETUP/ACCESS transfers.
- It returns read data and the slave error flag on a valid/ready response channel.
- Sits between the local controller and the APB interconnect that feeds the I2C slave.
- Handles exactly one outstanding transfer at a time.

Parameters:
- ADDR_W, 32, width of cmd_addr and paddr.
- DATA_W, 32, width of write data, read data and the APB data buses.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before abort; used only when APB_TIMEOUT_EN is defined; legal range 1..65535.

Ports:
- pclk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid is also high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data (ignored for reads).
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  pslverr captured, or timeout.
- paddr  out  ADDR_W  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  slave ready.
- pslverr  in  1  slave error.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: any cycle with rst high forces IDLE at the next edge. All outputs are 0: psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, busy. cmd_ready is 0 while rst is high.
- Reset mid-transfer aborts it. psel and penable drop on the next edge and no response is produced.
- State IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, register cmd_addr/cmd_write/cmd_wdata into paddr/pwrite/pwdata and go to SETUP.
- State SETUP: psel = 1, penable = 0. Lasts exactly one cycle, then ACCESS.
- State ACCESS:
  - psel = 1, penable = 1.
  - paddr, pwrite and pwdata stay stable until the transfer completes.
  - Each cycle with pready = 0 is a wait state; stay in ACCESS.
  - When pready = 1, capture rsp_rdata (prdata for reads, 0 for writes) and rsp_err = pslverr, then go to RESP.
- State RESP:
  - psel = 0, penable = 0, rsp_valid = 1.
  - rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_ready, clear rsp_valid and go to IDLE.
- Response latency: minimum 3 cycles from command acceptance to rsp_valid (SETUP, ACCESS, RESP), plus one cycle per wait state.
- Throughput: one transfer per 4 cycles when rsp_ready is tied high. There is no back-to-back SETUP chaining, so psel always drops for at least one cycle between transfers.
- cmd_ready is 0 in SETUP, ACCESS and RESP.
- Edge cases:
  - cmd_valid held high in RESP is not accepted until the cycle after returning to IDLE.
  - pslverr is sampled only when penable & pready; it is ignored at all other times.
  - prdata is sampled only on the completing cycle.
  - rsp_ready asserted with rsp_valid = 0 has no effect.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to ACCESS and increments each wait cycle.
  - When it reaches TIMEOUT_CYCLES with pready still 0, the transfer is aborted: go to RESP with rsp_err = 1 and rsp_rdata = 0.
  - psel and penable drop the cycle after the abort.
  - A pready that arrives in the same cycle as the limit wins, and the transfer completes normally.
- Undefined: no counter; ACCESS waits indefinitely for pready.

Decomposition:
- Package apb_master_pkg holds:
  - the state enum apb_state_t {IDLE, SETUP, ACCESS, RESP};
  - the response struct apb_rsp_t {rdata, err};
  - the localparam TIMEOUT_CNT_W = 16.
- One natural sub-module, apb_timeout_counter (clear, enable, limit, expired). It is instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Write, zero wait: cmd_write=1, addr 0x04, wdata 0x0000_0123, pready=1.
  - SETUP/ACCESS on the next two cycles with paddr=0x04 and pwdata=0x123.
  - rsp_valid=1 on the 3rd cycle after acceptance, with rsp_err=0 and rsp_rdata=0.
- Read, 3 wait states: addr 0x08; pready low for 3 ACCESS cycles, then high with prdata=0x0000_00A5.
  - paddr stays stable throughout.
  - rsp_rdata=0xA5, rsp_valid at cycle 6.
- Slave error: read of addr 0x1C with pslverr=1 and pready=1 → rsp_err=1. A pslverr pulse outside penable&pready is ignored.
- Response backpressure: rsp_ready=0 for 5 cycles while cmd_valid stays high.
  - rsp_valid and the data hold steady.
  - cmd_ready=0 throughout; the next command is accepted one cycle after the rsp_ready handshake.
- Reset mid-ACCESS: assert rst for 1 cycle during a wait state.
  - Next edge gives psel=0, penable=0, rsp_valid=0, busy=0.
  - No response is ever produced for the aborted command.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=4): pready held low → abort after 4 wait cycles with rsp_err=1 and rsp_rdata=0. Repeating with pready rising exactly at the limit completes normally with rsp_err=0.
